// File: rtl/aes_pkg.sv
// Shared types and constants for the byte-serial AES-128 key expander.
package aes_pkg;

    typedef logic [31:0] aes_word_t;

    typedef enum logic [2:0] {
        KX_IDLE,
        KX_EMIT,
        KX_SUB,
        KX_MIX,
        KX_DONE
    } kx_state_t;

    localparam int AES128_NR = 10;

    // Byte k of RotWord(w), k=0 being the most significant byte.
    function automatic logic [7:0] rot_byte(input aes_word_t w, input logic [1:0] k);
        case (k)
            2'd0:    rot_byte = w[23:16];
            2'd1:    rot_byte = w[15:8];
            2'd2:    rot_byte = w[7:0];
            default: rot_byte = w[31:24];
        endcase
    endfunction

endpackage

// File: rtl/aes_key_exp_round_contant_rom.sv
// Round-constant ROM: rcon word for rounds 1..10, zero for every other index.
module aes_key_exp_round_contant_rom
    import aes_pkg::*;
(
    input  logic [3:0] round_number,
    output aes_word_t  rcon
);

    always_comb begin
        rcon = '0;
        case (round_number)
            4'd1:    rcon = 32'h0100_0000;
            4'd2:    rcon = 32'h0200_0000;
            4'd3:    rcon = 32'h0400_0000;
            4'd4:    rcon = 32'h0800_0000;
            4'd5:    rcon = 32'h1000_0000;
            4'd6:    rcon = 32'h2000_0000;
            4'd7:    rcon = 32'h4000_0000;
            4'd8:    rcon = 32'h8000_0000;
            4'd9:    rcon = 32'h1b00_0000;
            4'd10:   rcon = 32'h3600_0000;
            default: rcon = '0;
        endcase
    end

endmodule

// File: rtl/aes_key_expander_seq.sv
// Byte-serial AES-128 key expansion: streams round keys 0..10 over valid/ready,
// borrowing the shared external S-box one byte per cycle for SubWord.
module aes_key_expander_seq
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_NR
) (
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] rk,
    output logic         done,
    output logic [7:0]   sbox_addr,
    input  logic [7:0]   sbox_data
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    kx_state_t  r_state;
    aes_word_t  r_w0, r_w1, r_w2, r_w3;
    aes_word_t  r_tmp;
    logic [3:0] r_rnd;
    logic [1:0] r_k;

    logic [3:0] w_round_number;
    aes_word_t  w_rcon, w_t, w_n0, w_n1, w_n2, w_n3;

    // The ROM is only addressed during MIX so it reads zero the rest of the time.
    assign w_round_number = (r_state == KX_MIX) ? r_rnd : 4'd0;

    aes_key_exp_round_contant_rom u_rcon_rom (
        .round_number (w_round_number),
        .rcon         (w_rcon)
    );

    assign w_t  = r_tmp ^ w_rcon;
    assign w_n0 = r_w0 ^ w_t;
    assign w_n1 = r_w1 ^ w_n0;
    assign w_n2 = r_w2 ^ w_n1;
    assign w_n3 = r_w3 ^ w_n2;

    assign rk       = {r_w0, r_w1, r_w2, r_w3};
    assign rk_index = r_rnd;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= KX_IDLE;
            r_w0      <= '0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            r_tmp     <= '0;
            r_rnd     <= '0;
            r_k       <= '0;
            busy      <= 1'b0;
            rk_valid  <= 1'b0;
            done      <= 1'b0;
            sbox_addr <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                KX_IDLE: begin
                    if (start) begin
                        r_w0     <= key_in[127:96];
                        r_w1     <= key_in[95:64];
                        r_w2     <= key_in[63:32];
                        r_w3     <= key_in[31:0];
                        r_rnd    <= '0;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        r_state  <= KX_EMIT;
                    end
                end
                KX_EMIT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (r_rnd == LAST_RND) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= KX_DONE;
                        end else begin
                            r_rnd     <= r_rnd + 4'd1;
                            r_k       <= '0;
                            sbox_addr <= rot_byte(r_w3, 2'd0);
                            r_state   <= KX_SUB;
                        end
                    end
                end
                KX_SUB: begin
                    // Shifting in MSB-first leaves byte 0 in tmp[31:24] after four cycles.
                    r_tmp <= {r_tmp[23:0], sbox_data};
                    r_k   <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        sbox_addr <= '0;
                        r_state   <= KX_MIX;
                    end else begin
                        sbox_addr <= rot_byte(r_w3, r_k + 2'd1);
                    end
                end
                KX_MIX: begin
                    r_w0     <= w_n0;
                    r_w1     <= w_n1;
                    r_w2     <= w_n2;
                    r_w3     <= w_n3;
                    rk_valid <= 1'b1;
                    r_state  <= KX_EMIT;
                end
                KX_DONE: begin
                    r_state <= KX_IDLE;
                end
                default: begin
                    r_state <= KX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Self-checking bench for aes_key_expander_seq against a word-level FIPS-197 key schedule model.
module tb_aes_key_expander_seq;

    logic         HCLK;
    logic         HRESETn;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [3:0]   rk_index;
    logic [127:0] rk;
    logic         done;
    logic [7:0]   sbox_addr;
    logic [7:0]   sbox_data;

    aes_key_expander_seq dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_index  (rk_index),
        .rk        (rk),
        .done      (done),
        .sbox_addr (sbox_addr),
        .sbox_data (sbox_data)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [7:0]    sbox_mem [256];
    logic [2047:0] sbox_flat;
    assign sbox_data = sbox_mem[sbox_addr];

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_rk  [11];
    logic [127:0] got_rk  [11];
    logic [3:0]   got_idx [11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rk_valid"}, rk_valid, 0);
        chk({tag, "_rk_index"}, rk_index, 0);
        chk({tag, "_rk"}, rk, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_sbox_addr"}, sbox_addr, 0);
    endtask

    // FIPS-197 key schedule over 44 words.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_mem[t[31:24]], sbox_mem[t[23:16]], sbox_mem[t[15:8]], sbox_mem[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Runs one expansion from IDLE; pct = percent chance rk_ready is high each cycle.
    task automatic run_key(input logic [127:0] key, input int pct, input bit restart);
        logic [127:0] prev_rk;
        logic [3:0]   prev_idx;
        logic [7:0]   exp_addr [4];
        logic [7:0]   addr_q [$];
        int           rn_q [$];
        bit           stall, done_seen, restarted;
        int           n_acc, cyc, sub_cnt;

        model_expand(key);
        exp_addr[0] = key[23:16];
        exp_addr[1] = key[15:8];
        exp_addr[2] = key[7:0];
        exp_addr[3] = key[31:24];
        stall = 0; done_seen = 0; restarted = 0;
        n_acc = 0; sub_cnt = 0; cyc = 1;
        prev_rk = '0; prev_idx = '0;
        key_in = key;
        start = 1'b1;
        while (!done_seen && cyc < 3000) begin
            @(posedge HCLK);
            @(negedge HCLK);
            cyc++;
            start = 1'b0;
            if (restart && n_acc == 4 && !restarted) begin
                start = 1'b1;
                key_in = ~key;
                restarted = 1;
            end
            if (stall) begin
                chk("stall_rk", rk, prev_rk);
                chk("stall_idx", rk_index, prev_idx);
                chk("stall_valid", rk_valid, 1);
            end
            if (dut.w_round_number != 4'd0) rn_q.push_back(int'(dut.w_round_number));
            if (sub_cnt >= 1 && sub_cnt <= 4) begin
                addr_q.push_back(sbox_addr);
                sub_cnt++;
            end else if (sub_cnt == 5) begin
                chk("sbox_addr_mix", sbox_addr, 0);
                sub_cnt = 0;
            end
            if (done) begin
                done_seen = 1;
                chk("busy_at_done", busy, 0);
                if (pct >= 100) chk("done_cycle", cyc, 63);
            end else begin
                chk("busy_running", busy, 1);
            end
            rk_ready = ($urandom_range(99) < pct);
            stall = rk_valid && !rk_ready;
            prev_rk = rk;
            prev_idx = rk_index;
            if (rk_valid && rk_ready) begin
                if (n_acc < 11) begin
                    got_rk[n_acc] = rk;
                    got_idx[n_acc] = rk_index;
                end
                if (n_acc == 0) sub_cnt = 1;
                n_acc++;
            end
        end
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got=no done after %0d cycles expected=done", cyc);
        end
        chk("accept_count", n_acc, 11);
        for (int i = 0; i < 11 && i < n_acc; i++) begin
            chk($sformatf("rk%0d", i), got_rk[i], exp_rk[i]);
            chk($sformatf("rk_index%0d", i), got_idx[i], i);
        end
        chk("sbox_addr_count", addr_q.size(), 4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++)
            chk($sformatf("sbox_addr_r1_%0d", i), addr_q[i], exp_addr[i]);
        chk("round_number_count", rn_q.size(), 10);
        for (int i = 0; i < 10 && i < rn_q.size(); i++)
            chk($sformatf("round_number_%0d", i), rn_q[i], i + 1);
        if (restart) begin
            start = 1'b1;
            key_in = ~key;
        end
        @(posedge HCLK);
        @(negedge HCLK);
        start = 1'b0;
        if (restart) begin
            chk("start_at_done_busy", busy, 0);
            chk("start_at_done_valid", rk_valid, 0);
            @(posedge HCLK);
            @(negedge HCLK);
        end
        key_in = key;
    endtask

    initial begin
        bit found;

        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
        };
        for (int i = 0; i < 256; i++) sbox_mem[i] = sbox_flat[2047 - 8*i -: 8];

        vecs[0] = '{FIPS_KEY, 0, FIPS_KEY};
        vecs[1] = '{FIPS_KEY, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{FIPS_KEY, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{128'h0, 1, 128'h62636363626363636263636362636363};
        vecs[4] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

        start = 1'b0;
        key_in = '0;
        rk_ready = 1'b0;
        HRESETn = 1'b1;
        #2 HRESETn = 1'b0;
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_reset_outputs("idle");

        for (int v = 0; v < 5; v++) begin
            run_key(vecs[v].key, 100, 0);
            chk($sformatf("vec%0d_idx%0d", v, vecs[v].idx), got_rk[vecs[v].idx], vecs[v].rk);
        end

        run_key(FIPS_KEY, 30, 0);
        run_key(FIPS_KEY, 100, 1);

        // Asynchronous abort during SUB of round 6.
        rk_ready = 1'b1;
        key_in = FIPS_KEY;
        start = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (rk_valid && rk_index == 4'd5) found = 1;
            else begin
                @(posedge HCLK);
                @(negedge HCLK);
            end
        end
        chk("abort_reach_rk5", found, 1);
        @(posedge HCLK);
        @(negedge HCLK);
        chk("abort_pre_busy", busy, 1);
        #2 HRESETn = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) begin
            @(posedge HCLK);
            #1 chk("abort_hold_done", done, 0);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        check_reset_outputs("after_abort");
        run_key(FIPS_KEY, 100, 0);

        for (int n = 0; n < 4; n++) begin
            logic [127:0] rkey;
            rkey = {$urandom, $urandom, $urandom, $urandom};
            run_key(rkey, $urandom_range(100, 20), n[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
